// File: rtl/chunked_adder_pkg.sv
// Shared types and helpers for the chunked multi-cycle adder.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Number of adder passes needed to cover one full-width operand.
  function automatic int nchunks(input int xlen, input int chunk);
    return xlen / chunk;
  endfunction

endpackage

// File: rtl/chunked_adder_seq_ripple_carry_adder.sv
// Ripple-carry adder slice built from a chain of single-bit full adders.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module ripple_carry_adder #(
  parameter int xlen = 16
) (
  input  logic [xlen-1:0] a,
  input  logic [xlen-1:0] b,
  input  logic            cin,
  output logic [xlen-1:0] sum,
  output logic            cout
);

  logic [xlen:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[xlen];

  for (genvar i = 0; i < xlen; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

endmodule

// File: rtl/chunked_adder_seq.sv
// Multi-cycle add/subtract that walks one narrow adder across the operands,
// least significant chunk first, with valid/ready on both sides.
module chunked_adder_seq
  import chunked_adder_pkg::*;
#(
  parameter int xlen  = 64,
  parameter int chunk = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [xlen-1:0] a,
  input  logic [xlen-1:0] b,
  input  logic            sub,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [xlen-1:0] sum,
  output logic            carry_out,
  output logic            overflow,
  output logic            busy
);

  localparam int NC = nchunks(xlen, chunk);
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;

  if ((xlen % chunk) != 0) begin : g_bad_cfg
    $error("chunked_adder_seq: xlen must be a multiple of chunk");
  end

  seq_state_t state;
  logic [xlen-1:0] opa;
  logic [xlen-1:0] opb;
  logic            carry_q;
  logic [CW-1:0]   cnt;
  logic            sa;
  logic            sb;

  logic [chunk-1:0] add_sum;
  logic             add_cout;
  logic [xlen-1:0]  acc_next;
  logic             last_chunk;
  logic             accept;

  ripple_carry_adder #(
    .xlen (chunk)
  ) u_rca (
    .a    (opa[chunk-1:0]),
    .b    (opb[chunk-1:0]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign accept       = start_valid && start_ready;
  assign last_chunk   = (cnt == CW'(NC - 1));

  // Partial sums enter from the top; only the upper chunks need storage
  // because the final pass delivers the complete word straight into sum.
  if (NC > 1) begin : g_multi
    logic [xlen-chunk-1:0] acc;

    assign acc_next = {add_sum, acc};

    always_ff @(posedge clk) begin
      if (rst) begin
        acc <= '0;
      end else if (state == RUN) begin
        acc <= acc_next[xlen-1:chunk];
      end
    end
  end else begin : g_single
    assign acc_next = add_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opa     <= a;
            opb     <= sub ? ~b : b;
            carry_q <= sub;
            cnt     <= '0;
            sa      <= a[xlen-1];
            sb      <= sub ? ~b[xlen-1] : b[xlen-1];
            state   <= RUN;
          end
        end
        RUN: begin
          opa     <= opa >> chunk;
          opb     <= opb >> chunk;
          carry_q <= add_cout;
          cnt     <= cnt + 1'b1;
          // Results are published only on completion so sum holds its
          // previous value while the next operation is in flight.
          if (last_chunk) begin
            sum       <= acc_next;
            carry_out <= add_cout;
            overflow  <= (sa == sb) && (acc_next[xlen-1] != sa);
            state     <= DONE;
          end
        end
        DONE: begin
          if (result_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/chunked_adder_seq.md
Name: chunked_adder_seq

Overview:
Multi-cycle sequencer that performs an xlen-bit add or subtract by time-multiplexing one chunk-wide ripple_carry_adder over xlen/chunk cycles. It trades latency for a short carry chain and a small adder. It sits between an issuing stage and a consuming stage, with valid/ready handshakes on both sides. It produces sum, unsigned carry-out and signed overflow.

Parameters:
- xlen, 64, operand/result width in bits.
- chunk, 16, adder slice width per cycle. xlen must be an integer multiple of chunk, checked by an elaboration-time assertion.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  request present.
- start_ready  output  1  block can accept a request.
- a  input  xlen  first operand.
- b  input  xlen  second operand.
- sub  input  1  1 = a - b, 0 = a + b.
- result_valid  output  1  sum, carry_out and overflow are valid.
- result_ready  input  1  consumer accepts result.
- sum  output  xlen  result.
- carry_out  output  1  final carry; for subtract, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, result_valid=0, sum=0, carry_out=0, overflow=0, internal registers=0. start_ready is combinational and is 1 the cycle after reset.
- States:
  - IDLE: start_ready=1. On start_valid&&start_ready, go to RUN and capture:
    - opa=a.
    - opb = sub ? ~b : b.
    - carry register = sub.
    - chunk counter = 0.
    - signs: sa=a[xlen-1], sb=opb[xlen-1].
  - RUN: each cycle, the adder computes opa[chunk-1:0] + opb[chunk-1:0] + carry.
    - opa and opb shift right by chunk.
    - The adder sum shifts into the sum register from the top, so after nchunks cycles chunk 0 sits in the low bits.
    - The carry register takes the adder carry_out.
    - The counter increments. On counter==nchunks-1, go to DONE.
  - DONE: result_valid=1.
    - carry_out = final carry.
    - overflow = (sa==sb) && (sum[xlen-1]!=sa).
    - On result_ready, go to IDLE and drop result_valid the next cycle.
- Latency: request accepted at edge 0; result_valid rises at edge nchunks (4 for defaults).
  - Throughput is one operation per nchunks+1 cycles minimum, because start_ready=0 in DONE.
- Handshake rules:
  - start_ready=0 in RUN and DONE; start_valid there is ignored and causes no capture.
  - sum, carry_out and overflow are held stable while result_valid=1 and result_ready=0.
  - result_ready while result_valid=0 has no effect.
  - A, b and sub only need to be valid in the accept cycle.
- Widths: counter width is $clog2(nchunks), minimum 1. No wrap is possible because the counter resets on accept.
- chunk==xlen: RUN lasts exactly one cycle; latency is 1.
- sum/carry_out/overflow are undefined-free. They retain their last result in IDLE until the next completion or reset.
- Reset mid-RUN or mid-DONE: the operation is aborted with no result emitted.

Decomposition:
- Package chunked_adder_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t.
  - Function nchunks(xlen, chunk).
- One sub-module: ripple_carry_adder, instantiated with its xlen parameter set to chunk. It is built from full_adder. No other sub-modules.

Test Plan:
- Defaults, a=1, b=1, sub=0 -> result_valid at 4th edge after accept; sum=2, carry_out=0, overflow=0.
- a=0x0000_FFFF_FFFF_FFFF, b=1, add -> sum=0x0001_0000_0000_0000, carry_out=0 (carry crosses 3 chunk boundaries).
- Carry and overflow cases:
  - a=0xFFFF_FFFF_FFFF_FFFF, b=1, add -> sum=0, carry_out=1, overflow=0.
  - a=0x7FFF_FFFF_FFFF_FFFF, b=1, add -> sum=0x8000_0000_0000_0000, overflow=1, carry_out=0.
- Subtract cases:
  - a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, carry_out=0, overflow=0.
  - a=7, b=5, sub=1 -> sum=2, carry_out=1.
- Backpressure: hold result_ready=0 for 3 cycles with start_valid=1 -> outputs stable, start_ready=0, no new capture. Then raise result_ready -> IDLE, and start_ready=1 the next cycle.
- Reset and config:
  - Assert rst during the 2nd RUN cycle -> next cycle IDLE, result_valid=0, sum=0, and no result is ever emitted for that request.
  - Repeat the first two scenarios with chunk=64 -> 1-cycle latency.
